// File: rtl/generic_fifo_sc_rd_if.sv
`default_nettype none
// ============================================================================
//  Module      : generic_fifo_sc_rd_if
//  Description : Bundles the FIFO read-port pins and the downstream
//                valid/ready stream of the read-side drain controller.
//                master : drain controller view (drives fifo_re and stream)
//                slave  : environment view (FIFO + downstream consumer)
//  Signals     : fifo_dout  FIFO read data, valid one cycle after fifo_re
//                fifo_empty FIFO empty flag
//                fifo_re    FIFO read strobe
//                out_data   stream data
//                out_valid  stream valid
//                out_ready  stream ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface generic_fifo_sc_rd_if #(
    parameter int dw = 8
);
    logic [dw-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_re;
    logic [dw-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  out_ready,
        output fifo_re,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output out_ready,
        input  fifo_re,
        input  out_data,
        input  out_valid
    );
endinterface
`default_nettype wire

// File: rtl/generic_skid2.sv
`default_nettype none
// ============================================================================
//  Module      : generic_skid2
//  Description : 2-entry valid/ready skid buffer with synchronous flush.
//                Entries are held as head (oldest) and tail. A push and a pop
//                on the same edge shift first, then append.
//  Ports       : clk, rst (async, active-low), flush (sync clear),
//                in_valid/in_data (write side, caller guarantees room),
//                out_valid/out_data/out_ready (stream side),
//                count (current occupancy 0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module generic_skid2 #(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [dw-1:0] in_data,
    output logic          out_valid,
    output logic [dw-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    count
);

    logic [dw-1:0] head;
    logic [dw-1:0] tail;
    logic          pop;

    // Valid comes only from stored state, never from out_ready.
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= in_data;
                    end else begin
                        tail <= in_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Shift then append: with one entry the new word
                    // becomes the head, with two it goes behind the old tail.
                    if (count == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/generic_fifo_sc_rd.sv
`default_nettype none
// ============================================================================
//  Module      : generic_fifo_sc_rd
//  Description : Read-side drain controller for the single-clock generic
//                FIFO. Issues read strobes, absorbs the one-cycle RAM read
//                latency and presents data on a valid/ready stream through a
//                2-entry skid buffer at up to one word per cycle.
//  Ports       : clk       clock
//                rst       asynchronous reset, active-low
//                clr       synchronous flush (shared with the FIFO)
//                bus       FIFO read pins + output stream (master modport)
//                busy      skid non-empty or read in flight
//                drop_cnt  saturating count of in-flight words lost to clr
//  Revision    : 1.0 - initial release
// ============================================================================
module generic_fifo_sc_rd #(
    parameter int dw   = 8,
    parameter int SKID = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    generic_fifo_sc_rd_if.master    bus,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam logic [2:0] SKID_DEPTH = 3'd2;

    logic          pend;
    logic [1:0]    count;
    logic          skid_valid;
    logic [dw-1:0] skid_data;
    logic          pop;
    logic [2:0]    proj;
    logic          re;

    assign pop = skid_valid & bus.out_ready;

    // Occupancy one edge from now: stored words plus the word returning
    // from the RAM, minus the word leaving this cycle. Issuing only while
    // this is below the depth guarantees a slot for every returning word.
    assign proj = {1'b0, count} + {2'b00, pend} - {2'b00, pop};
    assign re   = rst & ~clr & ~bus.fifo_empty & (proj < SKID_DEPTH);

    assign bus.fifo_re   = re;
    assign bus.out_valid = skid_valid;
    assign bus.out_data  = skid_data;
    assign busy          = (count != 2'd0) | pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (clr) begin
            pend <= 1'b0;
            if (pend && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else begin
            pend <= re;
        end
    end

    generic_skid2 #(
        .dw (dw)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (clr),
        .in_valid  (pend),
        .in_data   (bus.fifo_dout),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .out_ready (bus.out_ready),
        .count     (count)
    );

    a_skid_bound : assert property (@(posedge clk) disable iff (!rst)
        (count <= 2'(SKID)));

endmodule
`default_nettype wire

// File: tb/tb_generic_fifo_sc_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_generic_fifo_sc_rd
//  Description : Self-checking bench for generic_fifo_sc_rd. A small
//                behavioural single-clock FIFO with registered read data
//                feeds the DUT; a queue of written words is the reference
//                for stream ordering, and a word-ownership count bounds the
//                words held by the drain controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_fifo_sc_rd;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       we;
    logic       fifo_init;
    logic [7:0] din;
    logic       busy;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    generic_fifo_sc_rd_if #(.dw(8)) bus ();

    generic_fifo_sc_rd #(.dw(8), .SKID(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .bus      (bus),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FIFO (16 deep, registered read) ----------
    logic [7:0] mem [16];
    logic [4:0] wp;
    logic [4:0] rp;
    logic [7:0] dout_q;
    logic [4:0] fifo_level;
    int         rd_empty_errs = 0;

    assign bus.fifo_empty = (wp == rp);
    assign bus.fifo_dout  = dout_q;
    assign fifo_level     = wp - rp;

    always @(posedge clk) begin
        if (fifo_init || clr) begin
            wp <= 5'd0;
            rp <= 5'd0;
        end else begin
            if (we) begin
                mem[wp[3:0]] <= din;
                wp <= wp + 5'd1;
            end
            if (bus.fifo_re) begin
                if (wp == rp) rd_empty_errs <= rd_empty_errs + 1;
                dout_q <= mem[rp[3:0]];
                rp <= rp + 5'd1;
            end
        end
    end

    // ---------------- checking ---------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model / monitor ----------------------------
    logic [7:0] exp_q [$];
    int         held = 0;          // words owned by the DUT (stored or in flight)
    int         exp_drop = 0;
    int         re_pulses = 0;
    int         valid_cycles = 0;
    logic       prev_stall = 1'b0;
    logic       prev_re = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       mon_pop;

    assign mon_pop = bus.out_valid & bus.out_ready;

    always @(negedge clk) begin
        if (!rst) begin
            held       <= 0;
            prev_stall <= 1'b0;
            prev_re    <= 1'b0;
        end else begin
            check_eq("drop_cnt", {24'd0, drop_cnt}, exp_drop);
            if (bus.fifo_re) re_pulses <= re_pulses + 1;
            if (bus.out_valid) valid_cycles <= valid_cycles + 1;
            if (clr) begin
                check_eq("re_during_clr", {31'd0, bus.fifo_re}, 0);
                if (prev_re && exp_drop < 255) exp_drop <= exp_drop + 1;
                exp_q.delete();
                held       <= 0;
                prev_stall <= 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("hold_valid", {31'd0, bus.out_valid}, 1);
                    check_eq("hold_data", {24'd0, bus.out_data}, {24'd0, prev_data});
                end
                if (mon_pop) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_word", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
                    end else begin
                        check_eq("data_order", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
                    end
                end
                check_eq("busy_model", {31'd0, busy}, (held != 0) ? 1 : 0);
                check_eq("occupancy_le2",
                         ((held + int'(bus.fifo_re) - int'(mon_pop)) <= 2) ? 1 : 0, 1);
                held       <= held + int'(bus.fifo_re) - int'(mon_pop);
                prev_stall <= bus.out_valid & ~bus.out_ready;
                prev_data  <= bus.out_data;
            end
            prev_re <= bus.fifo_re;
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        we  = 1'b1;
        din = d;
        exp_q.push_back(d);
        tick();
        we  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.out_ready = 1'b1;
        while ((busy || !bus.fifo_empty) && n < 200) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", (n < 200) ? 1 : 0, 1);
    endtask

    // ---------------- test sequence ----------------------------------------
    initial begin
        logic [7:0] w [5];
        int         r0;
        int         v0;
        int         n;
        logic       found;

        rst = 1'b0; clr = 1'b0; we = 1'b0; din = 8'd0; fifo_init = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        fifo_init = 1'b0;

        // Reset with a preloaded FIFO
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_re", {31'd0, bus.fifo_re}, 0);
            check_eq("rst_valid", {31'd0, bus.out_valid}, 0);
            check_eq("rst_busy", {31'd0, busy}, 0);
            tick();
        end
        check_eq("rst_data", {24'd0, bus.out_data}, 0);
        check_eq("rst_drop", {24'd0, drop_cnt}, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_re", {31'd0, bus.fifo_re}, 1);
        check_eq("rel_valid0", {31'd0, bus.out_valid}, 0);
        tick();
        @(negedge clk);
        check_eq("rel_pend_valid", {31'd0, bus.out_valid}, 0);
        check_eq("rel_pend_busy", {31'd0, busy}, 1);
        tick();
        @(negedge clk);
        check_eq("rel_valid1", {31'd0, bus.out_valid}, 1);
        check_eq("rel_data", {24'd0, bus.out_data}, 32'h11);
        tick();
        wait_idle();

        // Streaming 0x01..0x10 with no bubbles
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_eq("stream_valid", {31'd0, bus.out_valid}, 1);
            check_eq("stream_data", {24'd0, bus.out_data}, i + 1);
        end
        @(negedge clk);
        check_eq("stream_end_valid", {31'd0, bus.out_valid}, 0);
        check_eq("stream_end_empty", {31'd0, bus.fifo_empty}, 1);
        tick();

        // Backpressure: only two reads while stalled
        bus.out_ready = 1'b0;
        r0 = re_pulses;
        for (int i = 0; i < 5; i++) begin
            w[i] = 8'($urandom);
            push_word(w[i]);
        end
        repeat (10) tick();
        check_eq("bp_re_pulses", re_pulses - r0, 2);
        @(negedge clk);
        check_eq("bp_valid", {31'd0, bus.out_valid}, 1);
        check_eq("bp_head", {24'd0, bus.out_data}, {24'd0, w[0]});
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid_run", {31'd0, bus.out_valid}, 1);
            check_eq("bp_data", {24'd0, bus.out_data}, {24'd0, w[i]});
        end
        tick();
        wait_idle();

        // Alternating ready
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'($urandom));
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 64) begin
            bus.out_ready = (n % 2 == 0);
            tick();
            n++;
        end
        check_eq("alt_drained", exp_q.size(), 0);
        check_eq("alt_timeout", (n < 64) ? 1 : 0, 1);
        wait_idle();

        // clr with a word in flight and one stored
        bus.out_ready = 1'b0;
        push_word(8'h5A);
        push_word(8'hA5);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.fifo_re && busy && !bus.out_valid) found = 1'b1;
        end
        check_eq("clr_setup", {31'd0, found}, 1);
        tick();
        clr = 1'b1;
        @(negedge clk);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check_eq("clr_valid", {31'd0, bus.out_valid}, 0);
        check_eq("clr_busy", {31'd0, busy}, 0);
        check_eq("clr_drop", {24'd0, drop_cnt}, 1);
        tick();
        push_word(8'hAA);
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.out_valid) found = 1'b1;
        end
        check_eq("post_clr_seen", {31'd0, found}, 1);
        check_eq("post_clr_data", {24'd0, bus.out_data}, 32'hAA);
        tick();
        wait_idle();

        // Single word, FIFO going empty
        bus.out_ready = 1'b1;
        r0 = re_pulses;
        v0 = valid_cycles;
        push_word(8'h3C);
        repeat (6) tick();
        check_eq("single_re", re_pulses - r0, 1);
        check_eq("single_valid", valid_cycles - v0, 1);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            we  = (fifo_level < 5'd14) && ($urandom_range(0, 2) != 0);
            din = 8'($urandom);
            if (we) exp_q.push_back(din);
            clr = ($urandom_range(0, 59) == 0);
            bus.out_ready = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick();
        end
        we  = 1'b0;
        clr = 1'b0;
        wait_idle();
        repeat (3) tick();
        check_eq("final_drained", exp_q.size(), 0);
        check_eq("read_while_empty", rd_empty_errs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
